// File: rtl/mux4_rr_arbiter_pkg.sv
// rtl/mux4_rr_arbiter_pkg.sv - shared constants for the 4-way round-robin arbiter
// Optional feature macro: ARB_TIMEOUT_EN (hold-time limit, used by the top).
// Contents: arbiter state encoding, requester count, default hold limit.
package mux4_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int NUM_REQ      = 4;
    localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// rtl/mux4_rr_arbiter_rr_pick4.sv - combinational round-robin search over 4 requesters
// Ports:
//   req_mask_i  4-bit candidate mask
//   start_i     index where the search begins (wraps modulo 4)
//   found_o     high when any mask bit is set
//   idx_o       first set index at or after start_i
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_mask_i,
    input  logic [1:0]         start_i,
    output logic               found_o,
    output logic [1:0]         idx_o
);

    logic [1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = start_i;
        cand    = start_i;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            cand = start_i + 2'(j);
            if (req_mask_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - 4-way round-robin arbiter driving a shared 4:1 data path
// Optional feature macro: ARB_TIMEOUT_EN (owner loses the grant after MAX_HOLD
// cycles when another requester waits).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req             request vector, one bit per requester
//   I0..I3          requester data
//   gnt             registered one-hot grant (zero when idle)
//   s               registered owner index
//   valid           registered, high while a grant is held
//   o               I[s] while valid, zero otherwise
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int W        = 5,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [W-1:0]       I0,
    input  logic [W-1:0]       I1,
    input  logic [W-1:0]       I2,
    input  logic [W-1:0]       I3,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         s,
    output logic               valid,
    output logic [W-1:0]       o
);

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..15");
    end

    state_e             state_q, state_d;
    logic [1:0]         s_q, s_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               valid_q, valid_d;

    logic [NUM_REQ-1:0] pick_mask;
    logic [1:0]         pick_start;
    logic               pick_found;
    logic [1:0]         pick_idx;
    logic               new_grant;
    logic               release_busy;
    logic               timeout_rot;

    // One search serves both cases: from ptr when idle, from s+1 with the
    // current owner masked out when busy.
    always_comb begin
        pick_mask  = req;
        pick_start = ptr_q;
        if (state_q == ST_BUSY) begin
            pick_mask  = req & ~gnt_q;
            pick_start = s_q + 2'd1;
        end
    end

    rr_pick4 u_pick (
        .req_mask_i (pick_mask),
        .start_i    (pick_start),
        .found_o    (pick_found),
        .idx_o      (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_inc;

    // Saturates at MAX_HOLD so a late-arriving waiter still forces rotation.
    assign cnt_inc     = (cnt_q == 4'(MAX_HOLD)) ? cnt_q : cnt_q + 4'd1;
    assign timeout_rot = (state_q == ST_BUSY) && (cnt_inc == 4'(MAX_HOLD)) && pick_found;

    always_comb begin
        cnt_d = cnt_q;
        if (new_grant || state_q == ST_IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_rot = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        valid_d      = valid_q;
        new_grant    = 1'b0;
        release_busy = 1'b0;
        case (state_q)
            ST_IDLE: begin
                new_grant = pick_found;
            end
            ST_BUSY: begin
                if (!req[s_q] || timeout_rot) begin
                    new_grant    = pick_found;
                    release_busy = !pick_found;
                end
            end
            default: release_busy = 1'b1;
        endcase
        if (new_grant) begin
            state_d = ST_BUSY;
            s_d     = pick_idx;
            gnt_d   = 4'b0001 << pick_idx;
            valid_d = 1'b1;
            ptr_d   = pick_idx + 2'd1;
        end else if (release_busy) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        o = '0;
        if (valid_q) begin
            case (s_q)
                2'd0:    o = I0;
                2'd1:    o = I1;
                2'd2:    o = I2;
                default: o = I3;
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign s     = s_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [4:0] dat [4];
    logic [3:0] gnt;
    logic [1:0] s;
    logic       valid;
    logic [4:0] o;

    int total;
    int bad;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] s;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] gnt;
        logic [1:0] s;
        logic       v;
        logic [4:0] o;
    } exp_t;

    vec_t vecs [28];
    exp_t sb [$];

    mux4_rr_arbiter #(.W(5), .MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .I0    (dat[0]),
        .I1    (dat[1]),
        .I2    (dat[2]),
        .I3    (dat[3]),
        .gnt   (gnt),
        .s     (s),
        .valid (valid),
        .o     (o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty");
            return;
        end
        e = sb.pop_front();
        total++;
        if (gnt !== e.gnt) begin
            bad++;
            $display("FAIL %s gnt got=%b want=%b", e.name, gnt, e.gnt);
        end
        total++;
        if (s !== e.s) begin
            bad++;
            $display("FAIL %s s got=%0d want=%0d", e.name, s, e.s);
        end
        total++;
        if (valid !== e.v) begin
            bad++;
            $display("FAIL %s valid got=%b want=%b", e.name, valid, e.v);
        end
        total++;
        if (o !== e.o) begin
            bad++;
            $display("FAIL %s o got=%0d want=%0d", e.name, o, e.o);
        end
    endtask

    task automatic step(input string name, input logic r, input logic [3:0] rq,
                        input logic [3:0] eg, input logic [1:0] es);
        exp_t e;
        rst    = r;
        req    = rq;
        e.name = name;
        e.gnt  = eg;
        e.s    = es;
        e.v    = |eg;
        e.o    = (|eg) ? dat[es] : 5'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = 4'b0000;
        dat[0] = 5'd1;
        dat[1] = 5'd2;
        dat[2] = 5'd3;
        dat[3] = 5'd4;

        // reset, then idle
        vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0};
        vecs[1]  = '{1'b0, 4'b0000, 4'b0000, 2'd0};
        vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 2'd0};
        vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd0};
        vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 2'd0};
        vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 2'd0};
        // all requesting, owner drops one cycle after each grant
        vecs[6]  = '{1'b0, 4'b1111, 4'b0001, 2'd0};
        vecs[7]  = '{1'b0, 4'b1110, 4'b0010, 2'd1};
        vecs[8]  = '{1'b0, 4'b1101, 4'b0100, 2'd2};
        vecs[9]  = '{1'b0, 4'b1011, 4'b1000, 2'd3};
        vecs[10] = '{1'b0, 4'b0111, 4'b0001, 2'd0};
        vecs[11] = '{1'b0, 4'b0000, 4'b0000, 2'd0};
        // lone requester 2, release, then ptr=3 wraps to requester 0
        vecs[12] = '{1'b0, 4'b0100, 4'b0100, 2'd2};
        vecs[13] = '{1'b0, 4'b0100, 4'b0100, 2'd2};
        vecs[14] = '{1'b0, 4'b0000, 4'b0000, 2'd2};
        vecs[15] = '{1'b0, 4'b0101, 4'b0001, 2'd0};
        vecs[16] = '{1'b0, 4'b0000, 4'b0000, 2'd0};
        // reset in the middle of a grant to requester 1
        vecs[17] = '{1'b0, 4'b0010, 4'b0010, 2'd1};
        vecs[18] = '{1'b0, 4'b0010, 4'b0010, 2'd1};
        vecs[19] = '{1'b1, 4'b0010, 4'b0000, 2'd0};
        vecs[20] = '{1'b0, 4'b0010, 4'b0010, 2'd1};
        vecs[21] = '{1'b0, 4'b0000, 4'b0000, 2'd1};
        // simultaneous requests resolved from ptr=2, not by fixed priority
        vecs[22] = '{1'b0, 4'b1011, 4'b1000, 2'd3};
        vecs[23] = '{1'b0, 4'b0011, 4'b0001, 2'd0};
        // owner 0 drops and re-raises while 1 waits: 1 served first
        vecs[24] = '{1'b0, 4'b0010, 4'b0010, 2'd1};
        vecs[25] = '{1'b0, 4'b0011, 4'b0010, 2'd1};
        vecs[26] = '{1'b0, 4'b0001, 4'b0001, 2'd0};
        vecs[27] = '{1'b0, 4'b0000, 4'b0000, 2'd0};

        for (int i = 0; i < 28; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].gnt, vecs[i].s);
        end

        // two constant requesters: rotation every 8 cycles only with the timeout
        for (int i = 0; i < 4; i++) dat[i] = 5'($urandom_range(0, 31));
        step("hold_rst", 1'b1, 4'b0000, 4'b0000, 2'd0);
        for (int k = 0; k < 24; k++) begin
            logic [3:0] eg;
            logic [1:0] es;
            eg = 4'b0001;
            es = 2'd0;
            if (TMO && ((k / 8) % 2 == 1)) begin
                eg = 4'b0010;
                es = 2'd1;
            end
            step($sformatf("hold2_%0d", k), 1'b0, 4'b0011, eg, es);
        end

        // lone owner keeps the grant past MAX_HOLD; a late waiter then
        // takes over at once only if the saturated counter is present
        step("solo_rst", 1'b1, 4'b0000, 4'b0000, 2'd0);
        for (int k = 0; k < 20; k++) begin
            step($sformatf("solo_%0d", k), 1'b0, 4'b0001, 4'b0001, 2'd0);
        end
        step("late_waiter", 1'b0, 4'b0011, TMO ? 4'b0010 : 4'b0001, TMO ? 2'd1 : 2'd0);
        step("late_release", 1'b0, 4'b0000, 4'b0000, TMO ? 2'd1 : 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
